// File: rtl/basketball_hoop_fx.sv
// Hoop sprite (pole, backboard, rim, net) for the VGA pixel pipeline.
// A score pulse starts a timed FLASH: rim blinks, net ripples, score counts.
module basketball_hoop_fx #(
    parameter int POLE_X_L     = 630,
    parameter int POLE_X_R     = 635,
    parameter int POLE_Y_T     = 120,
    parameter int POLE_Y_B     = 479,
    parameter int BOARD_X_L    = 630,
    parameter int BOARD_X_R    = 633,
    parameter int BOARD_Y_T    = 110,
    parameter int BOARD_Y_B    = 160,
    parameter int RIM_X_L      = 610,
    parameter int RIM_X_R      = 630,
    parameter int RIM_Y_T      = 155,
    parameter int RIM_Y_B      = 159,
    parameter int NET_H        = 12,
    parameter int NET_INSET    = 2,
    parameter int FLASH_FRAMES = 30,
    parameter int BLINK_FRAMES = 4,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               frame_tick,
    input  logic               score_pulse,
    output logic [11:0]        object_rgb,
    output logic               object_on,
    output logic               flash_active,
    output logic [SCORE_W-1:0] score_count
);

    localparam int FW = $clog2(FLASH_FRAMES) + 1;
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    localparam logic [9:0] P_XL = 10'(POLE_X_L);
    localparam logic [9:0] P_XR = 10'(POLE_X_R);
    localparam logic [9:0] P_YT = 10'(POLE_Y_T);
    localparam logic [9:0] P_YB = 10'(POLE_Y_B);
    localparam logic [9:0] B_XL = 10'(BOARD_X_L);
    localparam logic [9:0] B_XR = 10'(BOARD_X_R);
    localparam logic [9:0] B_YT = 10'(BOARD_Y_T);
    localparam logic [9:0] B_YB = 10'(BOARD_Y_B);
    localparam logic [9:0] R_XL = 10'(RIM_X_L);
    localparam logic [9:0] R_XR = 10'(RIM_X_R);
    localparam logic [9:0] R_YT = 10'(RIM_Y_T);
    localparam logic [9:0] R_YB = 10'(RIM_Y_B);
    localparam logic [9:0] N_XL = 10'(RIM_X_L + NET_INSET);
    localparam logic [9:0] N_XR = 10'(RIM_X_R - NET_INSET);
    localparam logic [9:0] N_YT = 10'(RIM_Y_B + 1);
    localparam logic [9:0] N_YB = 10'(RIM_Y_B + NET_H);

    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_GRAY   = 12'h555;

    typedef enum logic {
        IDLE,
        FLASH
    } state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [1:0]         net_phase_q, net_phase_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [11:0]        rgb_q, rgb_d;
    logic               on_q, on_d;
    logic               flash_q;

    logic       rim_hit, net_hit, board_hit, pole_hit;
    logic [9:0] ripple;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        net_phase_d = net_phase_q;
        score_d     = score_q;
        if (score_pulse) begin
            state_d     = FLASH;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
            net_phase_d = '0;
            if (score_q != '1) begin
                score_d = score_q + 1'b1;
            end
        end else if (state_q == FLASH && frame_tick) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            net_phase_d = net_phase_q + 1'b1;
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
            // Last frame of the effect: fall back to a clean IDLE
            if (frame_cnt_q == FW'(FLASH_FRAMES - 1)) begin
                state_d     = IDLE;
                frame_cnt_d = '0;
                blink_cnt_d = '0;
                blink_on_d  = 1'b0;
                net_phase_d = '0;
            end
        end
    end

    assign ripple = pixel_x - R_XL + pixel_y + {8'd0, net_phase_q};

    assign rim_hit = pixel_x >= R_XL && pixel_x <= R_XR &&
                     pixel_y >= R_YT && pixel_y <= R_YB;
    assign net_hit = pixel_x >= N_XL && pixel_x <= N_XR &&
                     pixel_y >= N_YT && pixel_y <= N_YB &&
                     ripple[1:0] == 2'b00;
    assign board_hit = pixel_x >= B_XL && pixel_x <= B_XR &&
                       pixel_y >= B_YT && pixel_y <= B_YB;
    assign pole_hit = pixel_x >= P_XL && pixel_x <= P_XR &&
                      pixel_y >= P_YT && pixel_y <= P_YB;

    always_comb begin
        rgb_d = '0;
        on_d  = 1'b0;
        if (video_on) begin
            if (rim_hit) begin
                on_d  = 1'b1;
                rgb_d = (state_q == FLASH && blink_on_q) ? C_YELLOW : C_RED;
            end else if (net_hit) begin
                on_d  = 1'b1;
                rgb_d = C_WHITE;
            end else if (board_hit) begin
                on_d  = 1'b1;
                rgb_d = C_WHITE;
            end else if (pole_hit) begin
                on_d  = 1'b1;
                rgb_d = C_GRAY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            net_phase_q <= '0;
            score_q     <= '0;
            rgb_q       <= '0;
            on_q        <= 1'b0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            net_phase_q <= net_phase_d;
            score_q     <= score_d;
            rgb_q       <= rgb_d;
            on_q        <= on_d;
            flash_q     <= (state_d == FLASH);
        end
    end

    assign object_rgb   = rgb_q;
    assign object_on    = on_q;
    assign flash_active = flash_q;
    assign score_count  = score_q;

endmodule

// File: tb/tb_basketball_hoop_fx.sv
// Scoreboard bench for basketball_hoop_fx: directed scenarios plus random
// pixel/tick/score traffic against a frame-count reference model.
module tb_basketball_hoop_fx;

    localparam int SW   = 2;
    localparam int MAXS = (1 << SW) - 1;

    logic          clk;
    logic          reset_n;
    logic          video_on;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          frame_tick;
    logic          score_pulse;
    logic [11:0]   object_rgb;
    logic          object_on;
    logic          flash_active;
    logic [SW-1:0] score_count;

    basketball_hoop_fx #(.SCORE_W(SW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .video_on     (video_on),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .frame_tick   (frame_tick),
        .score_pulse  (score_pulse),
        .object_rgb   (object_rgb),
        .object_on    (object_on),
        .flash_active (flash_active),
        .score_count  (score_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rgb;
        int on;
        int fa;
        int sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: whether FLASH runs, and frames elapsed since entry
    bit m_flash;
    int m_t;
    int m_score;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit inr(input int x, input int y, input int xl,
                               input int xr, input int yt, input int yb);
        return x >= xl && x <= xr && y >= yt && y <= yb;
    endfunction

    function automatic void model_pix(input bit vo, input int x, input int y,
                                      output int rgb, output int on);
        int ph;
        bit yellow;
        ph     = m_flash ? (m_t % 4) : 0;
        yellow = m_flash && ((m_t / 4) % 2 == 0);
        rgb = 0;
        on  = 0;
        if (!vo) return;
        on = 1;
        if (inr(x, y, 610, 630, 155, 159))
            rgb = yellow ? 'hFF0 : 'hF00;
        else if (inr(x, y, 612, 628, 160, 171) && (((x - 610 + y + ph) & 3) == 0))
            rgb = 'hFFF;
        else if (inr(x, y, 630, 633, 110, 160))
            rgb = 'hFFF;
        else if (inr(x, y, 630, 635, 120, 479))
            rgb = 'h555;
        else
            on = 0;
    endfunction

    task automatic step(input bit vo, input int x, input int y,
                        input bit ft, input bit sp);
        exp_t e;
        @(negedge clk);
        video_on    = vo;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        frame_tick  = ft;
        score_pulse = sp;
        model_pix(vo, x, y, e.rgb, e.on);
        if (sp) begin
            m_flash = 1'b1;
            m_t     = 0;
            if (m_score < MAXS) m_score++;
        end else if (m_flash && ft) begin
            m_t++;
            if (m_t == 30) m_flash = 1'b0;
        end
        e.fa = int'(m_flash);
        e.sc = m_score;
        exp_q.push_back(e);
    endtask

    task automatic quiet_inputs();
        video_on    = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        frame_tick  = 1'b0;
        score_pulse = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        quiet_inputs();
        exp_q.delete();
        m_flash = 1'b0;
        m_t     = 0;
        m_score = 0;
        #1;
        chk("rst_rgb", int'(object_rgb), 0);
        chk("rst_on", int'(object_on), 0);
        chk("rst_flash", int'(flash_active), 0);
        chk("rst_score", int'(score_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rgb", int'(object_rgb), e.rgb);
                chk("on", int'(object_on), e.on);
                chk("flash_active", int'(flash_active), e.fa);
                chk("score", int'(score_count), e.sc);
            end
        end
    end

    initial begin
        int x;
        int y;
        reset_n = 1'b0;
        quiet_inputs();
        m_flash = 1'b0;
        m_t     = 0;
        m_score = 0;
        #12;
        chk("init_rgb", int'(object_rgb), 0);
        chk("init_on", int'(object_on), 0);
        chk("init_flash", int'(flash_active), 0);
        chk("init_score", int'(score_count), 0);
        @(negedge clk);
        reset_n = 1'b1;

        step(1, 620, 157, 0, 0);
        step(1, 630, 110, 0, 0);
        step(1, 633, 160, 0, 0);
        step(1, 634, 161, 0, 0);
        step(1, 635, 479, 0, 0);
        step(1, 636, 300, 0, 0);
        step(1, 630, 157, 0, 0);
        step(0, 620, 157, 0, 0);
        step(1, 610, 155, 1, 0);
        for (int i = 160; i < 174; i++) step(1, 612 + (i % 17), i, 0, 0);

        step(1, 620, 157, 0, 1);
        for (int i = 0; i < 32; i++) begin
            step(1, 620, 157, 1, 0);
            step(1, 612 + i % 17, 160 + i % 12, 0, 0);
        end

        step(1, 620, 157, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 620, 157, 1, 0);
        step(1, 620, 157, 1, 1);
        for (int i = 0; i < 31; i++) step(1, 615, 158, 1, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 620, 157, 0, 1);
            step(1, 620, 157, 1, 0);
        end
        step(1, 620, 157, 1, 0);
        do_reset();
        step(1, 620, 157, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                x = 600 + $urandom_range(0, 40);
                y = 100 + $urandom_range(0, 80);
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            step($urandom_range(0, 9) != 0, x, y,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
            if (i == 1500) begin
                step(1, 620, 157, 0, 1);
                step(1, 620, 157, 1, 0);
                do_reset();
            end
        end

        @(posedge clk);
        #3;
        chk("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
